// File: rtl/cpu_mem_sram.sv
// Word-addressed SRAM slave for the unified core memory port. Accept-to-ready latency is WAIT_CYCLES+1.
// No backpressure beyond the wait states: one request in flight, and req/addr/we/wdata are ignored while waiting.
module cpu_mem_sram #(
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_CYCLES = 0,
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_req,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [XLEN-1:0]   cpu_mem_wdata,
  output logic [XLEN-1:0]   cpu_mem_rdata,
  output logic              cpu_mem_ready,
  output logic              mem_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH_WORDS);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [XLEN-1:0]     wdata_q;

  logic [XLEN-1:0]     mem [DEPTH_WORDS];

  logic                in_idle;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_we;
  logic [XLEN-1:0]     cur_wdata;
  logic [IW-1:0]       idx;
  logic                hi_set;
  logic                in_range;
  logic                complete;
  logic                unused_addr_lsb;

  // With zero wait states the request completes on its accept edge, so the
  // live port values are used in IDLE and the latched copies in WAIT.
  assign in_idle   = (state == S_IDLE);
  assign cur_addr  = in_idle ? cpu_mem_addr  : addr_q;
  assign cur_we    = in_idle ? cpu_mem_we    : we_q;
  assign cur_wdata = in_idle ? cpu_mem_wdata : wdata_q;

  assign idx      = cur_addr[2 +: IW];
  assign hi_set   = |(cur_addr >> (2 + IW));
  assign in_range = !hi_set && ({1'b0, idx} < DEPTH_L);
  assign unused_addr_lsb = ^cur_addr[1:0];

  assign complete = (in_idle && cpu_mem_req && (WAIT_CYCLES == 0)) ||
                    (!in_idle && (cnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      cpu_mem_rdata <= '0;
      cpu_mem_ready <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      cpu_mem_ready <= 1'b0;
      mem_err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_mem_req) begin
            addr_q  <= cpu_mem_addr;
            we_q    <= cpu_mem_we;
            wdata_q <= cpu_mem_wdata;
            if (WAIT_CYCLES != 0) begin
              cnt   <= CW'(WAIT_CYCLES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (complete) begin
        cpu_mem_ready <= 1'b1;
        mem_err       <= !in_range;
        if (!cur_we) begin
          cpu_mem_rdata <= in_range ? mem[idx] : '0;
        end
      end
    end
  end

  // Array is not reset; the rst_n gate keeps a reset from committing a write.
  always_ff @(posedge clk) begin
    if (rst_n && complete && cur_we && in_range) begin
      mem[idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_sram.sv
// Bench for cpu_mem_sram: a zero-wait and a three-wait instance driven from a vector table plus corner sequences.
module tb_cpu_mem_sram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mem_sram #(.DEPTH_WORDS(512), .WAIT_CYCLES(0), .XLEN(32), .ADDR_W(32), .INIT_FILE("")) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_req(req[0]), .cpu_mem_we(we[0]), .cpu_mem_addr(addr[0]), .cpu_mem_wdata(wdata[0]),
    .cpu_mem_rdata(rdata[0]), .cpu_mem_ready(rdy[0]), .mem_err(err[0])
  );

  cpu_mem_sram #(.DEPTH_WORDS(512), .WAIT_CYCLES(3), .XLEN(32), .ADDR_W(32), .INIT_FILE("")) u_w3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_req(req[1]), .cpu_mem_we(we[1]), .cpu_mem_addr(addr[1]), .cpu_mem_wdata(wdata[1]),
    .cpu_mem_rdata(rdata[1]), .cpu_mem_ready(rdy[1]), .mem_err(err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          chk;
    int          cyc;
  } exp_t;

  typedef struct {
    int          k;
    bit          we;
    bit          drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          chk;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rdy[k] === 1'b1) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready inst=%0d actual=1 required=0 (cycle %0d)", k, cyc);
        end else begin
          mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("ready_cycle_%0d", k), cyc, mon_e.cyc);
          chk($sformatf("mem_err_%0d", k), {31'b0, err[k]}, {31'b0, mon_e.err});
          if (mon_e.chk) chk($sformatf("rdata_%0d", k), rdata[k], mon_e.rdata);
        end
      end
    end
  end

  task automatic xfer(input vec_t v);
    exp_t e;
    int   lat;
    bit   seen;
    lat = (v.k == 0) ? 0 : 3;
    @(negedge clk);
    req[v.k]   = 1'b1;
    we[v.k]    = v.we;
    addr[v.k]  = v.addr;
    wdata[v.k] = v.wdata;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.chk   = v.chk;
    e.cyc   = cyc + 1 + lat;
    push(v.k, e);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (v.drop && i == 0) begin
        req[v.k]  = 1'b0;
        we[v.k]   = 1'b1;
        addr[v.k] = 32'h20;
      end
      if (rdy[v.k] === 1'b1) seen = 1;
    end
    req[v.k] = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d addr=%h actual=no_ready required=ready", v.k, v.addr);
      if (v.k == 0) q0.delete();
      else          q1.delete();
    end
  endtask

  initial begin
    exp_t e;
    vec_t v;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end

    //          k  we drop addr           wdata          exp_rdata      err chk
    tbl[0]  = '{0, 1, 0, 32'h0000_0010, 32'hDEADBEEF, 32'h0,         0,  0};
    tbl[1]  = '{0, 0, 0, 32'h0000_0010, 32'h0,        32'hDEADBEEF,  0,  1};
    tbl[2]  = '{0, 1, 0, 32'h0000_0000, 32'h11111111, 32'h0,         0,  0};
    tbl[3]  = '{0, 1, 0, 32'h0000_0800, 32'h00000055, 32'h0,         1,  0};
    tbl[4]  = '{0, 0, 0, 32'h0000_0800, 32'h0,        32'h0,         1,  1};
    tbl[5]  = '{0, 0, 0, 32'h0000_0000, 32'h0,        32'h11111111,  0,  1};
    tbl[6]  = '{0, 0, 0, 32'h0000_0013, 32'h0,        32'hDEADBEEF,  0,  1};
    tbl[7]  = '{0, 1, 0, 32'h0000_07FC, 32'hA5A5A5A5, 32'h0,         0,  0};
    tbl[8]  = '{0, 0, 0, 32'h0000_07FC, 32'h0,        32'hA5A5A5A5,  0,  1};
    tbl[9]  = '{0, 0, 0, 32'h8000_0000, 32'h0,        32'h0,         1,  1};
    tbl[10] = '{1, 1, 0, 32'h0000_0004, 32'h00A00093, 32'h0,         0,  0};
    tbl[11] = '{1, 0, 0, 32'h0000_0004, 32'h0,        32'h00A00093,  0,  1};
    tbl[12] = '{1, 1, 0, 32'h0000_0020, 32'hCAFE0020, 32'h0,         0,  0};
    tbl[13] = '{1, 0, 1, 32'h0000_0004, 32'h0,        32'h00A00093,  0,  1};
    tbl[14] = '{1, 0, 0, 32'h0000_0020, 32'h0,        32'hCAFE0020,  0,  1};

    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ready_%0d", k), {31'b0, rdy[k]}, 32'h0);
      chk($sformatf("reset_err_%0d", k), {31'b0, err[k]}, 32'h0);
      chk($sformatf("reset_rdata_%0d", k), rdata[k], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) xfer(tbl[i]);

    // Back-to-back reads with req held: one completion per cycle.
    for (int i = 0; i < 8; i++) begin
      v = '{0, 1, 0, 32'(4 * i), 32'h100 + 32'(i), 32'h0, 0, 0};
      xfer(v);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'(4 * i);
      e.rdata = 32'h100 + 32'(i); e.err = 0; e.chk = 1; e.cyc = cyc + 1;
      push(0, e);
    end
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    chk("rdata_hold_ready", {31'b0, rdy[0]}, 32'h0);
    chk("rdata_hold_value", rdata[0], 32'h107);

    // Reset in the middle of a waited write: nothing commits, outputs clear at once.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwait_reset_ready", {31'b0, rdy[1]}, 32'h0);
    chk("midwait_reset_rdata", rdata[1], 32'h0);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v = '{1, 0, 0, 32'h20, 32'h0, 32'hCAFE0020, 0, 1};
    xfer(v);

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
